mux_8x1: RTL and testbench
==========================

Name: mux_8x1

Overview:
- Registered 8-to-1 data selector.
- Eight WIDTH-bit data inputs a..h; 3-bit select s picks one.
- Selected word is captured into an output register on the rising clock edge when enabled.
- Used as a generic datapath selection stage; one clock domain, synchronous active-high reset.

Parameters:
- WIDTH, 3, bit width of each data input and of out.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when high, out loads the selected input.
- a  input  WIDTH  data input 0 (selected by s=3'd0).
- b  input  WIDTH  data input 1 (s=3'd1).
- c  input  WIDTH  data input 2 (s=3'd2).
- d  input  WIDTH  data input 3 (s=3'd3).
- e  input  WIDTH  data input 4 (s=3'd4).
- f  input  WIDTH  data input 5 (s=3'd5).
- g  input  WIDTH  data input 6 (s=3'd6).
- h  input  WIDTH  data input 7 (s=3'd7).
- s  input  3  select.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  high the cycle after a capture (registered copy of en).

Behaviour:
- Reset:
  - rst high at a rising edge forces out = 0 and out_valid = 0.
  - rst has priority over en.
- Selection is fully decoded:
  - s = 0..7 maps to a, b, c, d, e, f, g, h respectively.
  - All 8 codes are legal; there is no default/illegal case.
  - The combinational select result is never X when s is a known value.
- Capture:
  - If rst = 0 and en = 1, out <= input selected by s at that edge.
  - Latency is exactly 1 clock from s/data to out.
- Hold:
  - If rst = 0 and en = 0, out keeps its previous value.
- Valid:
  - out_valid <= en every non-reset edge.
  - out_valid is high for exactly the cycles following capturing edges.
- Data inputs may change any cycle; only values present at the capturing edge matter.
- Changing s and data in the same cycle: the new s selects the new data at that edge.
- Reset mid-stream: the next edge clears out/out_valid regardless of en or s.
- The first capture after reset deassertion follows normally.
- No internal state besides out and out_valid; no handshake back-pressure.

Decomposition:
- Package mux_8x1_pkg:
  - constants NUM_IN = 8, SEL_W = 3, default WIDTH = 3.
  - typedef of select code (logic [SEL_W-1:0]).
  - named select constants SEL_A..SEL_H = 0..7.
- One sub-module, mux_8x1_sel:
  - purely combinational 8:1 selector, parameterised by WIDTH.
  - Top level instantiates it and adds the output/valid registers.

Test Plan:
- Reset: assert rst 2 cycles with en = 1, s = 3 -> out = 000, out_valid = 0; deassert -> next edge out = d.
- Select sweep:
  - Inputs: a = 000, b = 110, c = 100, d = 111, e = 101, f = 001, g = 011, h = 010; en = 1.
  - Stimulus: step s 0..7, one per cycle.
  - Expected: out one cycle later = 000, 110, 100, 111, 101, 001, 011, 010; out_valid = 1 throughout.
- Hold:
  - Capture with s = 1 (out = 110), then en = 0 and s = 3.
  - Expected: out stays 110 for all en-low cycles; out_valid = 0 one cycle after en drops.
  - Re-assert en -> out = 111.
- Data change: s fixed at 4; change e from 101 to 010 -> out follows 101 then 010, each one cycle after the input change.
- Reset mid-operation: en = 1, s = 7 (out = 010); pulse rst for one cycle -> out = 000, out_valid = 0 that cycle; next edge out = 010.
- Width: instantiate WIDTH = 8 with a..h = 8'h11..8'h88; sweep s -> out = matching byte per select code, no truncation.

Source files
------------

// File: rtl/mux_8x1_pkg.sv
// Shared constants and select-code type for the registered 8:1 selector.
package mux_8x1_pkg;

    localparam int NUM_IN        = 8;
    localparam int SEL_W         = 3;
    localparam int DEFAULT_WIDTH = 3;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_A = 3'd0;
    localparam sel_t SEL_B = 3'd1;
    localparam sel_t SEL_C = 3'd2;
    localparam sel_t SEL_D = 3'd3;
    localparam sel_t SEL_E = 3'd4;
    localparam sel_t SEL_F = 3'd5;
    localparam sel_t SEL_G = 3'd6;
    localparam sel_t SEL_H = 3'd7;

endpackage

// File: rtl/mux_8x1_sel.sv
// Purely combinational 8:1 word selector; every select code maps to one input.
module mux_8x1_sel
    import mux_8x1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] e_i,
    input  logic [WIDTH-1:0] f_i,
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] h_i,
    input  sel_t             s_i,
    output logic [WIDTH-1:0] y_o
);

    // Decode the select code; the default arm only matters for a non-known select.
    always_comb begin
        y_o = '0;
        case (s_i)
            SEL_A:   y_o = a_i;
            SEL_B:   y_o = b_i;
            SEL_C:   y_o = c_i;
            SEL_D:   y_o = d_i;
            SEL_E:   y_o = e_i;
            SEL_F:   y_o = f_i;
            SEL_G:   y_o = g_i;
            SEL_H:   y_o = h_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/mux_8x1.sv
// Registered 8:1 data selector: captures the selected word when en is high
// and flags the following cycle with out_valid.
module mux_8x1
    import mux_8x1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_s;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    mux_8x1_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .a_i (a),
        .b_i (b),
        .c_i (c),
        .d_i (d),
        .e_i (e),
        .f_i (f),
        .g_i (g),
        .h_i (h),
        .s_i (s),
        .y_o (sel_s)
    );

    // Next-state: load the selected word on enable, otherwise hold.
    always_comb begin
        out_d   = out_q;
        valid_d = en;
        if (en) begin
            out_d = sel_s;
        end else begin
            out_d = out_q;
        end
    end

    // Output and valid registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1 (WIDTH=3 and WIDTH=8 instances) against an
// array-lookup reference model, with directed steps followed by random traffic.
module tb_mux_8x1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] s;

    logic [2:0] d3 [8];
    logic [7:0] d8 [8];

    logic [2:0] out3;
    logic       val3;
    logic [7:0] out8;
    logic       val8;

    logic [2:0] m_out3;
    logic [7:0] m_out8;
    logic       m_val;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_8x1 #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en),
        .a(d3[0]), .b(d3[1]), .c(d3[2]), .d(d3[3]),
        .e(d3[4]), .f(d3[5]), .g(d3[6]), .h(d3[7]),
        .s(s), .out(out3), .out_valid(val3)
    );

    mux_8x1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en),
        .a(d8[0]), .b(d8[1]), .c(d8[2]), .d(d8[3]),
        .e(d8[4]), .f(d8[5]), .g(d8[6]), .h(d8[7]),
        .s(s), .out(out8), .out_valid(val8)
    );

    // Drive one cycle of inputs, advance the model, clock, then check both DUTs.
    task automatic step(input logic r, input logic en_v, input logic [2:0] sel, input string tag);
        rst = r;
        en  = en_v;
        s   = sel;
        if (r) begin
            m_out3 = 3'd0;
            m_out8 = 8'd0;
            m_val  = 1'b0;
        end else begin
            if (en_v) begin
                m_out3 = d3[sel];
                m_out8 = d8[sel];
            end
            m_val = en_v;
        end
        @(posedge clk);
        #1;
        n_assert++;
        assert (out3 === m_out3) else begin
            n_fail++;
            $error("FAIL %s out3: observed %b expected %b", tag, out3, m_out3);
        end
        n_assert++;
        assert (val3 === m_val) else begin
            n_fail++;
            $error("FAIL %s valid3: observed %b expected %b", tag, val3, m_val);
        end
        n_assert++;
        assert (out8 === m_out8) else begin
            n_fail++;
            $error("FAIL %s out8: observed %h expected %h", tag, out8, m_out8);
        end
        n_assert++;
        assert (val8 === m_val) else begin
            n_fail++;
            $error("FAIL %s valid8: observed %b expected %b", tag, val8, m_val);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        s   = 3'd3;
        d3[0] = 3'b000; d3[1] = 3'b110; d3[2] = 3'b100; d3[3] = 3'b111;
        d3[4] = 3'b101; d3[5] = 3'b001; d3[6] = 3'b011; d3[7] = 3'b010;
        for (int i = 0; i < 8; i++) begin
            d8[i] = 8'(8'h11 * (i + 1));
        end
        m_out3 = 3'd0;
        m_out8 = 8'd0;
        m_val  = 1'b0;
        @(negedge clk);

        // Reset held two cycles with en high, then first capture.
        step(1'b1, 1'b1, 3'd3, "reset0");
        step(1'b1, 1'b1, 3'd3, "reset1");
        step(1'b0, 1'b1, 3'd3, "post_reset");

        // Select sweep.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i), "sweep");
        end

        // Hold with en low, then re-enable.
        step(1'b0, 1'b1, 3'd1, "hold_cap");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd3, "hold");
        end
        step(1'b0, 1'b1, 3'd3, "hold_reen");

        // Data change with fixed select.
        step(1'b0, 1'b1, 3'd4, "data_e0");
        d3[4] = 3'b010;
        step(1'b0, 1'b1, 3'd4, "data_e1");
        d3[4] = 3'b101;

        // Reset mid-operation.
        step(1'b0, 1'b1, 3'd7, "mid_pre");
        step(1'b1, 1'b1, 3'd7, "mid_rst");
        step(1'b0, 1'b1, 3'd7, "mid_post");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 8; k++) begin
                d3[k] = 3'($urandom_range(7));
                d8[k] = 8'($urandom_range(255));
            end
            step(($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(7)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
